// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_stage
// Purpose  : Decode->execute pipeline stage around the register file. Drives
//            the RF read addresses, selects operands from RF data or the
//            EX/MEM/WB bypass paths, inserts one bubble per load-use hazard
//            and holds a valid/ready output register that feeds EX.
// Ports    : CLK, RES (sync, active-low)
//            IN_*      : decode-side valid/ready handshake and instruction
//            RA_RF/RB_RF/A_RF/B_RF : RF read ports (combinational)
//            EX_RESULT, MEM_*, RW_RF/DW_RF/WE_RF : bypass sources
//            FLUSH     : branch redirect, kills output and offered input
//            OUT_*     : registered instruction towards EX (valid/ready)
//            STALL_CNT : saturating count of load-use bubbles
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RES,
  // decode side
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       IN_PC,
  input  logic [4:0]        IN_RS1,
  input  logic [4:0]        IN_RS2,
  input  logic [4:0]        IN_RD,
  input  logic              IN_USE_RS1,
  input  logic              IN_USE_RS2,
  input  logic              IN_IS_LOAD,
  input  logic [31:0]       IN_IMM,
  input  logic [CTRL_W-1:0] IN_CTRL,
  // register file read ports
  output logic [4:0]        RA_RF,
  output logic [4:0]        RB_RF,
  input  logic [31:0]       A_RF,
  input  logic [31:0]       B_RF,
  // bypass sources
  input  logic [31:0]       EX_RESULT,
  input  logic              MEM_VALID,
  input  logic [4:0]        MEM_RD,
  input  logic [31:0]       MEM_DATA,
  input  logic [4:0]        RW_RF,
  input  logic [31:0]       DW_RF,
  input  logic              WE_RF,
  // control
  input  logic              FLUSH,
  // execute side
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [31:0]       OUT_PC,
  output logic [31:0]       OUT_IMM,
  output logic [31:0]       OUT_A,
  output logic [31:0]       OUT_B,
  output logic [4:0]        OUT_RD,
  output logic              OUT_IS_LOAD,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [CNT_W-1:0]  STALL_CNT
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic              r_out_valid;
  logic [31:0]       r_out_pc;
  logic [31:0]       r_out_imm;
  logic [31:0]       r_out_a;
  logic [31:0]       r_out_b;
  logic [4:0]        r_out_rd;
  logic              r_out_is_load;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_adv;
  logic              w_haz;
  logic [31:0]       w_opa;
  logic [31:0]       w_opb;

  // Operand select for one source. The EX path is only usable for non-loads:
  // a load's value is not known until it leaves MEM, which is exactly the case
  // the hazard bubble covers.
  function automatic logic [31:0] f_sel_operand(
    input logic [4:0]  rs,
    input logic [31:0] rf_data,
    input logic        out_valid,
    input logic        out_is_load,
    input logic [4:0]  out_rd,
    input logic [31:0] ex_result,
    input logic        mem_valid,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data,
    input logic        we_rf,
    input logic [4:0]  rw_rf,
    input logic [31:0] dw_rf
  );
    logic [31:0] v;
    if (rs == 5'd0)
      v = 32'd0;
    else if (out_valid && !out_is_load && (out_rd == rs))
      v = ex_result;
    else if (mem_valid && (mem_rd == rs))
      v = mem_data;
    else if (we_rf && (rw_rf == rs))
      v = dw_rf;     // register being written on this same edge
    else
      v = rf_data;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  always_comb begin
    w_adv = !r_out_valid || OUT_READY;
    w_haz = r_out_valid && r_out_is_load && (r_out_rd != 5'd0) &&
            ((IN_USE_RS1 && (IN_RS1 == r_out_rd)) ||
             (IN_USE_RS2 && (IN_RS2 == r_out_rd)));
    // FLUSH makes the stage "accept" the offer so decode can drop it.
    IN_READY = RES && (FLUSH || (w_adv && !w_haz));
  end

  always_comb begin
    RA_RF = IN_RS1;
    RB_RF = IN_RS2;
    w_opa = f_sel_operand(IN_RS1, A_RF, r_out_valid, r_out_is_load, r_out_rd,
                          EX_RESULT, MEM_VALID, MEM_RD, MEM_DATA,
                          WE_RF, RW_RF, DW_RF);
    w_opb = f_sel_operand(IN_RS2, B_RF, r_out_valid, r_out_is_load, r_out_rd,
                          EX_RESULT, MEM_VALID, MEM_RD, MEM_DATA,
                          WE_RF, RW_RF, DW_RF);
  end

  // --------------------------------------------------------------------------
  // Sequential update: reset, flush, bubble, load, drain, hold
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RES) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'd0;
      r_out_imm     <= 32'd0;
      r_out_a       <= 32'd0;
      r_out_b       <= 32'd0;
      r_out_rd      <= 5'd0;
      r_out_is_load <= 1'b0;
      r_out_ctrl    <= '0;
      r_stall_cnt   <= '0;
    end else if (FLUSH) begin
      r_out_valid <= 1'b0;
    end else if (w_adv && w_haz) begin
      r_out_valid <= 1'b0;
      if (r_stall_cnt != c_cnt_max)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end else if (w_adv && IN_VALID) begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= IN_PC;
      r_out_imm     <= IN_IMM;
      r_out_a       <= w_opa;
      r_out_b       <= w_opb;
      r_out_rd      <= IN_RD;
      r_out_is_load <= IN_IS_LOAD;
      r_out_ctrl    <= IN_CTRL;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
    end
    // !w_adv: everything holds
  end

  always_comb begin
    OUT_VALID   = r_out_valid;
    OUT_PC      = r_out_pc;
    OUT_IMM     = r_out_imm;
    OUT_A       = r_out_a;
    OUT_B       = r_out_b;
    OUT_RD      = r_out_rd;
    OUT_IS_LOAD = r_out_is_load;
    OUT_CTRL    = r_out_ctrl;
    STALL_CNT   = r_stall_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch_stage
// Purpose  : Self-checking bench for operand_fetch_stage. Expected EX-side
//            instructions are queued when the stage accepts them and compared
//            when they appear on OUT_*. Counter width is reduced so that
//            saturation can be reached quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [4:0]        rd;
    logic              ld;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RES;
  logic              IN_VALID, IN_READY;
  logic [31:0]       IN_PC, IN_IMM;
  logic [4:0]        IN_RS1, IN_RS2, IN_RD;
  logic              IN_USE_RS1, IN_USE_RS2, IN_IS_LOAD;
  logic [CTRL_W-1:0] IN_CTRL;
  logic [4:0]        RA_RF, RB_RF;
  logic [31:0]       A_RF, B_RF, EX_RESULT, MEM_DATA, DW_RF;
  logic              MEM_VALID, WE_RF, FLUSH;
  logic [4:0]        MEM_RD, RW_RF;
  logic              OUT_VALID, OUT_READY, OUT_IS_LOAD;
  logic [31:0]       OUT_PC, OUT_IMM, OUT_A, OUT_B;
  logic [4:0]        OUT_RD;
  logic [CTRL_W-1:0] OUT_CTRL;
  logic [CNT_W-1:0]  STALL_CNT;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  operand_fetch_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RES(RES),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_PC(IN_PC),
    .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_RD(IN_RD),
    .IN_USE_RS1(IN_USE_RS1), .IN_USE_RS2(IN_USE_RS2), .IN_IS_LOAD(IN_IS_LOAD),
    .IN_IMM(IN_IMM), .IN_CTRL(IN_CTRL),
    .RA_RF(RA_RF), .RB_RF(RB_RF), .A_RF(A_RF), .B_RF(B_RF),
    .EX_RESULT(EX_RESULT), .MEM_VALID(MEM_VALID), .MEM_RD(MEM_RD),
    .MEM_DATA(MEM_DATA), .RW_RF(RW_RF), .DW_RF(DW_RF), .WE_RF(WE_RF),
    .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_IMM(OUT_IMM), .OUT_A(OUT_A), .OUT_B(OUT_B),
    .OUT_RD(OUT_RD), .OUT_IS_LOAD(OUT_IS_LOAD), .OUT_CTRL(OUT_CTRL),
    .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic ld,
                       input logic [31:0] imm, input logic [CTRL_W-1:0] ctrl);
    IN_VALID = 1'b1; IN_PC = pc; IN_RS1 = rs1; IN_RS2 = rs2; IN_RD = rd;
    IN_USE_RS1 = u1; IN_USE_RS2 = u2; IN_IS_LOAD = ld; IN_IMM = imm;
    IN_CTRL = ctrl;
  endtask

  task automatic clear_bypass();
    EX_RESULT = 32'd0; MEM_VALID = 1'b0; MEM_RD = 5'd0; MEM_DATA = 32'd0;
    WE_RF = 1'b0; RW_RF = 5'd0; DW_RF = 32'd0;
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic ld,
                              input logic [CTRL_W-1:0] ctrl);
    exp_t e;
    e.pc = pc; e.imm = imm; e.a = a; e.b = b; e.rd = rd; e.ld = ld; e.ctrl = ctrl;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.pc = OUT_PC; o.imm = OUT_IMM; o.a = OUT_A; o.b = OUT_B;
    o.rd = OUT_RD; o.ld = OUT_IS_LOAD; o.ctrl = OUT_CTRL;
    return o;
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    exp_t o;
    RES = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
    A_RF = 32'h11; B_RF = 32'h22;
    clear_bypass();
    offer(32'h80, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h9, 8'h5A);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (OUT_VALID !== 1'b0) begin
        n_bad++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID);
      end
      n_cmp++;
      if (IN_READY !== 1'b0) begin
        n_bad++; $display("FAIL reset_in_ready: got %b want 0", IN_READY);
      end
      n_cmp++;
      if (STALL_CNT !== '0) begin
        n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", STALL_CNT);
      end
    end
    o = observe();
    n_cmp++;
    if (o !== '0) begin
      n_bad++; $display("FAIL reset_out_fields: got %h want 0", o);
    end
    IN_VALID = 1'b0;
    RES = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_rf_path();
    exp_t e, o;
    offer(32'h100, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 32'h5, 8'h3C);
    #1;
    n_cmp++;
    if (RA_RF !== 5'd3 || RB_RF !== 5'd4) begin
      n_bad++; $display("FAIL rf_addr: got %0d/%0d want 3/4", RA_RF, RB_RF);
    end
    n_cmp++;
    if (IN_READY !== 1'b1) begin
      n_bad++; $display("FAIL rf_in_ready: got %b want 1", IN_READY);
    end
    sb.push_back(mk(32'h100, 32'h5, 32'h11, 32'h22, 5'd1, 1'b0, 8'h3C));
    tick();
    IN_VALID = 1'b0;
    n_cmp++;
    if (OUT_VALID !== 1'b1) begin
      n_bad++; $display("FAIL rf_out_valid: got %b want 1", OUT_VALID);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL rf_out: scoreboard empty");
    end else begin
      e = sb.pop_front(); o = observe();
      if (o !== e) begin
        n_bad++; $display("FAIL rf_out: got %h want %h", o, e);
      end
    end
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL rf_drain: got %b want 0", OUT_VALID);
    end
  endtask

  // --------------------------------------------------------------------------
  // Issues a sequence back to back, each step with its own bypass setting.
  task automatic test_priority();
    exp_t e, o;
    // X: writes x5, non-load, reads x0 only
    offer(32'h200, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0, 8'h01);
    sb.push_back(mk(32'h200, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 8'h01));
    tick();
    // Y: rs1=x5 with EX, MEM and WB all holding x5 -> EX wins
    EX_RESULT = 32'hAA; MEM_VALID = 1'b1; MEM_RD = 5'd5; MEM_DATA = 32'hBB;
    WE_RF = 1'b1; RW_RF = 5'd5; DW_RF = 32'hCC;
    offer(32'h204, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h1, 8'h02);
    #1;
    n_cmp++;
    if (IN_READY !== 1'b1) begin
      n_bad++; $display("FAIL prio_in_ready: got %b want 1", IN_READY);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL prio_x: scoreboard empty");
    end else begin
      e = sb.pop_front(); o = observe();
      if (OUT_VALID !== 1'b1 || o !== e) begin
        n_bad++; $display("FAIL prio_x: got v=%b %h want v=1 %h", OUT_VALID, o, e);
      end
    end
    sb.push_back(mk(32'h204, 32'h1, 32'hAA, 32'h0, 5'd0, 1'b0, 8'h02));
    tick();
    // Z: rs1=x0 while OUT, MEM point at x0 -> 0; rs2=x5 only in WB -> DW_RF
    MEM_RD = 5'd0;
    offer(32'h208, 5'd0, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0, 32'h2, 8'h03);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL prio_ex: scoreboard empty");
    end else begin
      e = sb.pop_front(); o = observe();
      if (OUT_VALID !== 1'b1 || o !== e) begin
        n_bad++; $display("FAIL prio_ex: got v=%b %h want v=1 %h", OUT_VALID, o, e);
      end
    end
    sb.push_back(mk(32'h208, 32'h2, 32'h0, 32'hCC, 5'd9, 1'b0, 8'h03));
    tick();
    // W: rs1=x5 in MEM and WB -> MEM wins; rs2=x9 in OUT -> EX_RESULT
    MEM_RD = 5'd5;
    offer(32'h20C, 5'd5, 5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 32'h3, 8'h04);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL prio_zero_wb: scoreboard empty");
    end else begin
      e = sb.pop_front(); o = observe();
      if (OUT_VALID !== 1'b1 || o !== e) begin
        n_bad++; $display("FAIL prio_zero_wb: got v=%b %h want v=1 %h", OUT_VALID, o, e);
      end
    end
    sb.push_back(mk(32'h20C, 32'h3, 32'hBB, 32'hAA, 5'd2, 1'b0, 8'h04));
    tick();
    IN_VALID = 1'b0;
    clear_bypass();
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL prio_mem: scoreboard empty");
    end else begin
      e = sb.pop_front(); o = observe();
      if (OUT_VALID !== 1'b1 || o !== e) begin
        n_bad++; $display("FAIL prio_mem: got v=%b %h want v=1 %h", OUT_VALID, o, e);
      end
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load_use();
    exp_t e, o;
    offer(32'h300, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 32'h4, 8'h10);
    sb.push_back(mk(32'h300, 32'h4, 32'h11, 32'h22, 5'd7, 1'b1, 8'h10));
    tick();
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL lu_load: scoreboard empty");
    end else begin
      e = sb.pop_front(); o = observe();
      if (OUT_VALID !== 1'b1 || o !== e) begin
        n_bad++; $display("FAIL lu_load: got v=%b %h want v=1 %h", OUT_VALID, o, e);
      end
    end
    offer(32'h304, 5'd2, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 32'h10, 8'h11);
    #1;
    n_cmp++;
    if (IN_READY !== 1'b0) begin
      n_bad++; $display("FAIL lu_stall_ready: got %b want 0", IN_READY);
    end
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0 || STALL_CNT !== 3'd1) begin
      n_bad++; $display("FAIL lu_bubble: got v=%b cnt=%0d want v=0 cnt=1", OUT_VALID, STALL_CNT);
    end
    WE_RF = 1'b1; RW_RF = 5'd7; DW_RF = 32'h77;
    #1;
    n_cmp++;
    if (IN_READY !== 1'b1) begin
      n_bad++; $display("FAIL lu_resume_ready: got %b want 1", IN_READY);
    end
    sb.push_back(mk(32'h304, 32'h10, 32'h11, 32'h77, 5'd8, 1'b0, 8'h11));
    tick();
    IN_VALID = 1'b0;
    clear_bypass();
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL lu_dependent: scoreboard empty");
    end else begin
      e = sb.pop_front(); o = observe();
      if (OUT_VALID !== 1'b1 || o !== e) begin
        n_bad++; $display("FAIL lu_dependent: got v=%b %h want v=1 %h", OUT_VALID, o, e);
      end
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure_flush();
    exp_t e, o;
    offer(32'h400, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h6, 8'h20);
    sb.push_back(mk(32'h400, 32'h6, 32'h11, 32'h22, 5'd3, 1'b0, 8'h20));
    tick();
    OUT_READY = 1'b0;
    offer(32'h404, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 32'h7, 8'h21);
    e = (sb.size() != 0) ? sb[0] : '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (IN_READY !== 1'b0) begin
        n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, IN_READY);
      end
      tick();
      o = observe();
      n_cmp++;
      if (OUT_VALID !== 1'b1 || o !== e) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", i, OUT_VALID, o, e);
      end
    end
    FLUSH = 1'b1;
    #1;
    n_cmp++;
    if (IN_READY !== 1'b1) begin
      n_bad++; $display("FAIL flush_in_ready: got %b want 1", IN_READY);
    end
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    if (sb.size() != 0) void'(sb.pop_front());
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL flush_kill: got %b want 0", OUT_VALID);
    end
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL flush_drop_input: got %b want 0", OUT_VALID);
    end
  endtask

  // --------------------------------------------------------------------------
  // A chain of loads each reading the previous load's destination: every other
  // cycle is a bubble, pushing the counter past its saturation point.
  task automatic test_stall_saturation();
    exp_t e, o;
    logic want_rdy;
    offer(32'h500, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h8, 8'h30);
    for (int i = 0; i < 20; i++) begin
      #1;
      want_rdy = (i % 2 == 0);
      n_cmp++;
      if (IN_READY !== want_rdy) begin
        n_bad++; $display("FAIL sat_ready[%0d]: got %b want %b", i, IN_READY, want_rdy);
      end
      if (OUT_VALID === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL sat_out[%0d]: scoreboard empty", i);
        end else begin
          e = sb.pop_front(); o = observe();
          if (o !== e) begin
            n_bad++; $display("FAIL sat_out[%0d]: got %h want %h", i, o, e);
          end
        end
      end
      if (IN_READY === 1'b1)
        sb.push_back(mk(32'h500, 32'h8, 32'h11, 32'h0, 5'd7, 1'b1, 8'h30));
      tick();
    end
    IN_VALID = 1'b0;
    n_cmp++;
    if (STALL_CNT !== 3'd7) begin
      n_bad++; $display("FAIL sat_count: got %0d want 7", STALL_CNT);
    end
    n_cmp++;
    if (OUT_VALID !== 1'b0 || sb.size() != 0) begin
      n_bad++; $display("FAIL sat_drain: got v=%b pending=%0d want v=0 pending=0", OUT_VALID, sb.size());
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mid_reset();
    offer(32'h600, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h9, 8'h40);
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b1) begin
      n_bad++; $display("FAIL mreset_pre: got %b want 1", OUT_VALID);
    end
    OUT_READY = 1'b0;
    RES = 1'b0;
    #1;
    n_cmp++;
    if (IN_READY !== 1'b0) begin
      n_bad++; $display("FAIL mreset_in_ready: got %b want 0", IN_READY);
    end
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0 || OUT_PC !== 32'd0 || STALL_CNT !== '0) begin
      n_bad++; $display("FAIL mreset_clear: got v=%b pc=%h cnt=%0d want 0/0/0", OUT_VALID, OUT_PC, STALL_CNT);
    end
    RES = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_rf_path();
    test_priority();
    test_load_use();
    test_backpressure_flush();
    test_stall_saturation();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
